vec_lane_sequencer: RTL and testbench

VEC_LANE_SEQUENCER -- requirements
Module: vec_lane_sequencer

---
 rtl/vec_lane_sequencer.sv | 157 +++++++++++++++
 tb/tb_vec_lane_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
// Vector-op sequencer: feeds one lane per cycle to a shared lane ALU and assembles the 64-bit result; VSEQ_COMPMOV_FAST_EN lets VCOMPMOV skip the ALU.
// Latency: accept edge, then 4 unstalled RUN edges to DONE (1 for fast VCOMPMOV); one DONE edge back to IDLE.
// Backpressure: O_Ready only in IDLE; I_GPUStallSignal freezes RUN progress and holds DONE with the write enable asserted.
module vec_lane_sequencer #(
    parameter int LANES         = 4,
    parameter int LANE_W        = 16,
    parameter int VREG_ID_WIDTH = 5
) (
    input  logic                       I_CLOCK,
    input  logic                       I_RESET_N,
    input  logic                       I_Valid,
    output logic                       O_Ready,
    input  logic [1:0]                 I_Op,
    input  logic [LANES*LANE_W-1:0]    I_VecSrc1Value,
    input  logic [LANES*LANE_W-1:0]    I_VecSrc2Value,
    input  logic [LANE_W-1:0]          I_Scalar,
    input  logic [1:0]                 I_Idx,
    input  logic [VREG_ID_WIDTH-1:0]   I_DestVRegIdx,
    input  logic                       I_GPUStallSignal,
    output logic [1:0]                 O_LaneOp,
    output logic [LANE_W-1:0]          O_LaneA,
    output logic [LANE_W-1:0]          O_LaneB,
    input  logic [LANE_W-1:0]          I_LaneResult,
    output logic [LANES*LANE_W-1:0]    O_VecDestValue,
    output logic [VREG_ID_WIDTH-1:0]   O_DestVRegIdx,
    output logic                       O_VRegWEn,
    output logic                       O_Busy_Signal
);

    localparam int VEC_W = LANES * LANE_W;

    localparam logic [1:0] OP_VMOV     = 2'b10;
    localparam logic [1:0] OP_VCOMPMOV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [1:0]                 op_q, op_d;
    logic [1:0]                 idx_q, idx_d;
    logic [VEC_W-1:0]           src1_q, src1_d;
    logic [VEC_W-1:0]           src2_q, src2_d;
    logic [LANE_W-1:0]          scalar_q, scalar_d;
    logic [VREG_ID_WIDTH-1:0]   dest_q, dest_d;
    logic [VEC_W-1:0]           result_q, result_d;

    logic [LANE_W-1:0]          src1_lane;
    logic [LANE_W-1:0]          src2_lane;

    assign src1_lane = src1_q[cnt_q*LANE_W +: LANE_W];
    assign src2_lane = src2_q[cnt_q*LANE_W +: LANE_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        idx_d    = idx_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        scalar_d = scalar_q;
        dest_d   = dest_q;
        result_d = result_q;
        O_LaneOp = 2'b00;
        O_LaneA  = '0;
        O_LaneB  = '0;

        case (state_q)
            ST_IDLE: begin
                if (I_Valid && !I_GPUStallSignal) begin
                    op_d     = I_Op;
                    idx_d    = I_Idx;
                    src1_d   = I_VecSrc1Value;
                    src2_d   = I_VecSrc2Value;
                    scalar_d = I_Scalar;
                    dest_d   = I_DestVRegIdx;
                    cnt_d    = 2'd0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                O_LaneA = src1_lane;
                if (op_q == OP_VCOMPMOV) begin
                    // Compare-move rides the ALU's MOV path, which forwards operand B.
                    O_LaneOp = OP_VMOV;
                    O_LaneB  = (cnt_q == idx_q) ? scalar_q : src1_lane;
                end else begin
                    O_LaneOp = op_q;
                    O_LaneB  = src2_lane;
                end

                if (!I_GPUStallSignal) begin
`ifdef VSEQ_COMPMOV_FAST_EN
                    if (op_q == OP_VCOMPMOV) begin
                        result_d = src1_q;
                        result_d[idx_q*LANE_W +: LANE_W] = scalar_q;
                        cnt_d   = 2'd0;
                        state_d = ST_DONE;
                    end else
`endif
                    begin
                        result_d[cnt_q*LANE_W +: LANE_W] = I_LaneResult;
                        if (cnt_q == 2'(LANES - 1)) begin
                            cnt_d   = 2'd0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!I_GPUStallSignal) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            op_q     <= 2'b00;
            idx_q    <= 2'd0;
            src1_q   <= '0;
            src2_q   <= '0;
            scalar_q <= '0;
            dest_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            scalar_q <= scalar_d;
            dest_q   <= dest_d;
            result_q <= result_d;
        end
    end

    assign O_Ready        = (state_q == ST_IDLE);
    assign O_Busy_Signal  = !O_Ready;
    assign O_VRegWEn      = (state_q == ST_DONE);
    assign O_VecDestValue = result_q;
    assign O_DestVRegIdx  = dest_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Bench for vec_lane_sequencer: shared-lane ALU model plus a lane-wise reference of each vector op.
module tb_vec_lane_sequencer;

    localparam int VW = 5;
`ifdef VSEQ_COMPMOV_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          I_CLOCK;
    logic          I_RESET_N;
    logic          I_Valid;
    logic          O_Ready;
    logic [1:0]    I_Op;
    logic [63:0]   I_VecSrc1Value;
    logic [63:0]   I_VecSrc2Value;
    logic [15:0]   I_Scalar;
    logic [1:0]    I_Idx;
    logic [VW-1:0] I_DestVRegIdx;
    logic          I_GPUStallSignal;
    logic [1:0]    O_LaneOp;
    logic [15:0]   O_LaneA;
    logic [15:0]   O_LaneB;
    logic [15:0]   I_LaneResult;
    logic [63:0]   O_VecDestValue;
    logic [VW-1:0] O_DestVRegIdx;
    logic          O_VRegWEn;
    logic          O_Busy_Signal;

    int n_pass;
    int n_total;

    vec_lane_sequencer #(.LANES(4), .LANE_W(16), .VREG_ID_WIDTH(VW)) dut (
        .I_CLOCK          (I_CLOCK),
        .I_RESET_N        (I_RESET_N),
        .I_Valid          (I_Valid),
        .O_Ready          (O_Ready),
        .I_Op             (I_Op),
        .I_VecSrc1Value   (I_VecSrc1Value),
        .I_VecSrc2Value   (I_VecSrc2Value),
        .I_Scalar         (I_Scalar),
        .I_Idx            (I_Idx),
        .I_DestVRegIdx    (I_DestVRegIdx),
        .I_GPUStallSignal (I_GPUStallSignal),
        .O_LaneOp         (O_LaneOp),
        .O_LaneA          (O_LaneA),
        .O_LaneB          (O_LaneB),
        .I_LaneResult     (I_LaneResult),
        .O_VecDestValue   (O_VecDestValue),
        .O_DestVRegIdx    (O_DestVRegIdx),
        .O_VRegWEn        (O_VRegWEn),
        .O_Busy_Signal    (O_Busy_Signal)
    );

    initial begin
        I_CLOCK = 1'b1;
        forever #5 I_CLOCK = ~I_CLOCK;
    end

    // Shared lane ALU: ADD, AND, MOV (passes B); the unused code gives a distinct value.
    always_comb begin
        case (O_LaneOp)
            2'b00:   I_LaneResult = O_LaneA + O_LaneB;
            2'b01:   I_LaneResult = O_LaneA & O_LaneB;
            2'b10:   I_LaneResult = O_LaneB;
            default: I_LaneResult = O_LaneA ^ 16'h5A5A;
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] s1,
                                               input logic [63:0] s2, input logic [15:0] sc,
                                               input logic [1:0] idx);
        logic [63:0] r;
        logic [15:0] a, b;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a = s1[16*i +: 16];
            b = s2[16*i +: 16];
            case (op)
                2'b00:   r[16*i +: 16] = a + b;
                2'b01:   r[16*i +: 16] = a & b;
                2'b10:   r[16*i +: 16] = b;
                default: r[16*i +: 16] = (i == int'(idx)) ? sc : a;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_edges(input logic [1:0] op, input int stall_at, input int stall_len);
        int base;
        base = (FAST && op == 2'b11) ? 1 : 4;
        if (stall_at >= 0 && stall_at < base) return base + stall_len;
        return base;
    endfunction

    task automatic tick();
        @(negedge I_CLOCK);
        #2;
    endtask

    // Drives one op to completion; held_bad counts handshake/hold violations seen on the way.
    task automatic do_op(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [15:0] sc, input logic [1:0] idx, input logic [VW-1:0] dest,
                         input int stall_at, input int stall_len, input int done_stall,
                         output int edges, output logic [63:0] res, output logic [VW-1:0] dest_o,
                         output int held_bad);
        int  k;
        int  stalls_left;
        bit  stall_now;
        I_Op = op; I_VecSrc1Value = s1; I_VecSrc2Value = s2;
        I_Scalar = sc; I_Idx = idx; I_DestVRegIdx = dest;
        I_GPUStallSignal = 1'b0;
        I_Valid = 1'b1;
        tick();
        I_Valid = 1'b0;
        edges = 0; k = 0; stalls_left = stall_len; held_bad = 0;
        while (!O_VRegWEn && edges < 40) begin
            if (O_Ready || !O_Busy_Signal) held_bad++;
            stall_now = (k == stall_at) && (stalls_left > 0);
            I_GPUStallSignal = stall_now;
            if (stall_now) stalls_left--;
            tick();
            edges++;
            if (stall_now && !(FAST && op == 2'b11) && O_LaneA !== s1[16*k +: 16]) held_bad++;
            if (!stall_now) k++;
        end
        I_GPUStallSignal = 1'b0;
        res = O_VecDestValue;
        dest_o = O_DestVRegIdx;
        if (O_LaneOp !== 2'b00 || O_LaneA !== 16'h0 || O_LaneB !== 16'h0) held_bad++;
        for (int d = 0; d < done_stall; d++) begin
            I_GPUStallSignal = 1'b1;
            tick();
            if (!O_VRegWEn || O_Ready || O_VecDestValue !== res) held_bad++;
        end
        I_GPUStallSignal = 1'b0;
        tick();
        if (O_VRegWEn || !O_Ready || O_Busy_Signal || O_VecDestValue !== res) held_bad++;
    endtask

    task automatic test_reset();
        I_RESET_N = 1'b0;
        I_Valid = 1'b0; I_Op = 2'b00; I_VecSrc1Value = '0; I_VecSrc2Value = '0;
        I_Scalar = '0; I_Idx = '0; I_DestVRegIdx = '0; I_GPUStallSignal = 1'b0;
        #13;
        n_total++;
        if (O_Ready !== 1'b1 || O_Busy_Signal !== 1'b0) $display("FAIL reset_ready: ready=%b busy=%b, required 1/0", O_Ready, O_Busy_Signal);
        else n_pass++;
        n_total++;
        if (O_VRegWEn !== 1'b0 || O_VecDestValue !== 64'h0 || O_DestVRegIdx !== '0)
            $display("FAIL reset_outputs: wen=%b vec=%h dest=%0d, required 0/0/0", O_VRegWEn, O_VecDestValue, O_DestVRegIdx);
        else n_pass++;
        n_total++;
        if (O_LaneOp !== 2'b00 || O_LaneA !== 16'h0 || O_LaneB !== 16'h0)
            $display("FAIL reset_lanes: op=%b a=%h b=%h, required zeros", O_LaneOp, O_LaneA, O_LaneB);
        else n_pass++;
        tick();
        I_RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_vadd();
        int edges, bad; logic [63:0] res; logic [VW-1:0] d;
        do_op(2'b00, 64'h0004_0003_0002_0001, 64'h0001_0001_0001_0001, 16'h0, 2'd0, 5'd7,
              -1, 0, 0, edges, res, d, bad);
        n_total++;
        if (res !== 64'h0005_0004_0003_0002) $display("FAIL vadd_result: got %h, required %h", res, 64'h0005_0004_0003_0002);
        else n_pass++;
        n_total++;
        if (edges !== 4) $display("FAIL vadd_latency: got %0d edges, required 4", edges);
        else n_pass++;
        n_total++;
        if (d !== 5'd7 || bad !== 0) $display("FAIL vadd_dest_hold: dest=%0d bad=%0d, required 7/0", d, bad);
        else n_pass++;
    endtask

    task automatic test_vand_stall();
        int edges, bad; logic [63:0] res, s1, s2; logic [VW-1:0] d;
        s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom};
        do_op(2'b01, s1, s2, 16'h0, 2'd0, 5'd3, 1, 2, 0, edges, res, d, bad);
        n_total++;
        if (res !== (s1 & s2)) $display("FAIL vand_result: got %h, required %h", res, s1 & s2);
        else n_pass++;
        n_total++;
        if (edges !== 6) $display("FAIL vand_stall_latency: got %0d edges, required 6", edges);
        else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL vand_stall_hold: %0d violations, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_compmov();
        int edges, bad; logic [63:0] res; logic [VW-1:0] d;
        do_op(2'b11, 64'h1111_2222_3333_4444, {$urandom, $urandom}, 16'hBEEF, 2'd2, 5'd9,
              -1, 0, 0, edges, res, d, bad);
        n_total++;
        if (res !== 64'h1111_BEEF_3333_4444) $display("FAIL compmov_result: got %h, required %h", res, 64'h1111_BEEF_3333_4444);
        else n_pass++;
        n_total++;
        if (edges !== (FAST ? 1 : 4)) $display("FAIL compmov_latency: got %0d edges, required %0d", edges, FAST ? 1 : 4);
        else n_pass++;
    endtask

    task automatic test_done_stall();
        int edges, bad; logic [63:0] res, s2; logic [VW-1:0] d;
        s2 = {$urandom, $urandom};
        do_op(2'b10, {$urandom, $urandom}, s2, 16'h0, 2'd0, 5'd30, -1, 0, 3, edges, res, d, bad);
        n_total++;
        if (res !== s2) $display("FAIL vmov_result: got %h, required %h", res, s2);
        else n_pass++;
        n_total++;
        if (bad !== 0 || d !== 5'd30) $display("FAIL done_stall_hold: bad=%0d dest=%0d, required 0/30", bad, d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int wen_seen;
        I_Op = 2'b00; I_VecSrc1Value = 64'h1234_5678_9ABC_DEF0; I_VecSrc2Value = 64'h0101_0101_0101_0101;
        I_DestVRegIdx = 5'd21; I_GPUStallSignal = 1'b0; I_Valid = 1'b1;
        tick();
        I_Valid = 1'b0;
        tick();
        tick();
        I_RESET_N = 1'b0;
        #1;
        n_total++;
        if (O_Ready !== 1'b1 || O_VRegWEn !== 1'b0 || O_VecDestValue !== 64'h0 || O_DestVRegIdx !== '0)
            $display("FAIL reset_mid_run: ready=%b wen=%b vec=%h dest=%0d, required 1/0/0/0", O_Ready, O_VRegWEn, O_VecDestValue, O_DestVRegIdx);
        else n_pass++;
        #1;
        I_RESET_N = 1'b1;
        wen_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (O_VRegWEn !== 1'b0 || O_Ready !== 1'b1) wen_seen++;
        end
        n_total++;
        if (wen_seen !== 0 || O_VecDestValue !== 64'h0) $display("FAIL reset_discard: bad_cycles=%0d vec=%h, required 0/0", wen_seen, O_VecDestValue);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2;
        int edges;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        I_GPUStallSignal = 1'b0;
        I_Op = 2'b00; I_VecSrc1Value = a1; I_VecSrc2Value = b1; I_DestVRegIdx = 5'd1; I_Valid = 1'b1;
        tick();
        I_Op = 2'b01; I_VecSrc1Value = a2; I_VecSrc2Value = b2; I_DestVRegIdx = 5'd2;
        edges = 0;
        while (!O_VRegWEn && edges < 20) begin tick(); edges++; end
        n_total++;
        if (edges !== 4 || O_VecDestValue !== ref_result(2'b00, a1, b1, 16'h0, 2'd0) || O_DestVRegIdx !== 5'd1)
            $display("FAIL b2b_first: edges=%0d vec=%h dest=%0d, required 4/%h/1", edges, O_VecDestValue, O_DestVRegIdx, ref_result(2'b00, a1, b1, 16'h0, 2'd0));
        else n_pass++;
        tick();
        n_total++;
        if (O_Ready !== 1'b1 || O_VRegWEn !== 1'b0) $display("FAIL b2b_idle: ready=%b wen=%b, required 1/0", O_Ready, O_VRegWEn);
        else n_pass++;
        tick();
        I_Valid = 1'b0;
        edges = 0;
        while (!O_VRegWEn && edges < 20) begin tick(); edges++; end
        n_total++;
        if (edges !== 4 || O_VecDestValue !== (a2 & b2) || O_DestVRegIdx !== 5'd2)
            $display("FAIL b2b_second: edges=%0d vec=%h dest=%0d, required 4/%h/2", edges, O_VecDestValue, O_DestVRegIdx, a2 & b2);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int edges, bad, sa, sl, ds;
        logic [63:0] res, s1, s2, exp_res;
        logic [VW-1:0] d, dest;
        logic [1:0] op, idx;
        logic [15:0] sc;
        for (int n = 0; n < 16; n++) begin
            op = 2'($urandom_range(0, 3)); idx = 2'($urandom_range(0, 3));
            s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom};
            sc = 16'($urandom); dest = VW'($urandom);
            sa = $urandom_range(0, 5); sl = $urandom_range(0, 2); ds = $urandom_range(0, 2);
            exp_res = ref_result(op, s1, s2, sc, idx);
            do_op(op, s1, s2, sc, idx, dest, sa, sl, ds, edges, res, d, bad);
            n_total++;
            if (res !== exp_res) $display("FAIL rand_result[%0d] op=%0d: got %h, required %h", n, op, res, exp_res);
            else n_pass++;
            n_total++;
            if (edges !== ref_edges(op, sa, sl)) $display("FAIL rand_latency[%0d] op=%0d: got %0d, required %0d", n, op, edges, ref_edges(op, sa, sl));
            else n_pass++;
            n_total++;
            if (d !== dest || bad !== 0) $display("FAIL rand_dest_hold[%0d]: dest=%0d bad=%0d, required %0d/0", n, d, bad, dest);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_vadd();
        test_vand_stall();
        test_compmov();
        test_done_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
